// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer_pkg
// Purpose  : Shared op-codes and sizing helper for the program sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

  // Sequencer operation codes
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_RBR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // Bits needed to hold an entry count in the range 0..depth inclusive
  function automatic int unsigned depth_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : program_sequencer_pkg
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_stack
// Purpose  : Parametrised LIFO holding return addresses. Only the entry
//            pointer is reset; storage contents are left as-is. The current
//            top entry is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module return_stack
  import program_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            push_data,
  output logic [WIDTH-1:0]            top_data,
  output logic                        full,
  output logic                        empty,
  output logic [depth_w(DEPTH)-1:0]   count
);

  localparam int CW = depth_w(DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_top_cnt;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;

  // Entry pointer maps the next free slot and the top slot to RAM indices
  always_comb begin
    w_top_cnt = r_count - 1'b1;
    w_wr_idx  = r_count[IW-1:0];
    w_rd_idx  = w_top_cnt[IW-1:0];
  end

  assign full     = (r_count == c_full_cnt);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign top_data = r_mem[w_rd_idx];

  // Entry pointer: push increments, pop decrements, guarded against limits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Storage write on push; contents are never cleared
  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule : return_stack
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Program counter with increment, jump, conditional branch and
//            call/return through an internal return stack, with sticky
//            stack overflow/underflow flags.
// Options  : PROGRAM_SEQUENCER_REL_BRANCH_EN - enables op 110 as a
//            PC-relative conditional branch; otherwise op 110 is a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 4,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       i_halt,
  input  logic [2:0]                 i_op,
  input  logic                       i_cond,
  input  logic [ADDR_W-1:0]          i_target,
  output logic [ADDR_W-1:0]          o_pc,
  output logic [depth_w(DEPTH)-1:0]  o_depth,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_upd;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
`ifdef PROGRAM_SEQUENCER_REL_BRANCH_EN
  logic [ADDR_W-1:0] w_rel;
`endif

  assign w_upd = clk_en & ~i_halt;
  assign w_inc = r_pc + 1'b1;
`ifdef PROGRAM_SEQUENCER_REL_BRANCH_EN
  // Two's-complement offset: a plain modular add gives the signed result
  assign w_rel = r_pc + i_target;
`endif

  // Op decode: next PC, stack strobes and error-flag set requests
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (i_op)
      OP_INC:  w_pc_nxt = w_inc;
      OP_JMP:  w_pc_nxt = i_target;
      OP_BR:   w_pc_nxt = i_cond ? i_target : w_inc;
      OP_CALL: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_push   = 1'b1;
          w_pc_nxt = i_target;
        end
      end
      OP_RET: begin
        if (w_empty) begin
          w_set_unf = 1'b1;
        end else begin
          w_pop    = 1'b1;
          w_pc_nxt = w_top;
        end
      end
`ifdef PROGRAM_SEQUENCER_REL_BRANCH_EN
      OP_RBR:  w_pc_nxt = i_cond ? w_rel : w_inc;
`endif
      default: w_pc_nxt = r_pc;
    endcase
  end

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_upd & w_push),
    .pop       (w_upd & w_pop),
    .push_data (w_inc),
    .top_data  (w_top),
    .full      (w_full),
    .empty     (w_empty),
    .count     (o_depth)
  );

  // PC and sticky error flags advance only on qualified cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_upd) begin
      r_pc <= w_pc_nxt;
      if (w_set_ovf) r_overflow  <= 1'b1;
      if (w_set_unf) r_underflow <= 1'b1;
    end
  end

  assign o_pc        = r_pc;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule : program_sequencer
`default_nettype wire
